// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the AXI4-Lite read-channel arbiter.
// Also holds the grant-index width helper used by the arbiter and its pick logic.
package axi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_t;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    // Keep a one-bit index even for a single requester so ports never collapse to zero width.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_lite_read_arbiter_if.sv
// AR/R channel bundle: NUM_REQ requester-side ports plus the single shared downstream port.
// The slave modport is the arbiter's view; master is the surrounding environment's view.
interface axi_lite_read_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0][31:0] s_axi_araddr;
    logic [NUM_REQ-1:0][2:0]  s_axi_arprot;
    logic [NUM_REQ-1:0]       s_axi_arvalid;
    logic [NUM_REQ-1:0]       s_axi_arready;
    logic [NUM_REQ-1:0][31:0] s_axi_rdata;
    logic [NUM_REQ-1:0][1:0]  s_axi_rresp;
    logic [NUM_REQ-1:0]       s_axi_rvalid;
    logic [NUM_REQ-1:0]       s_axi_rready;

    logic [31:0]              m_axi_araddr;
    logic [2:0]               m_axi_arprot;
    logic                     m_axi_arvalid;
    logic                     m_axi_arready;
    logic [31:0]              m_axi_rdata;
    logic [1:0]               m_axi_rresp;
    logic                     m_axi_rvalid;
    logic                     m_axi_rready;

    modport slave (
        input  s_axi_araddr, s_axi_arprot, s_axi_arvalid, s_axi_rready,
        input  m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid,
        output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
        output m_axi_araddr, m_axi_arprot, m_axi_arvalid, m_axi_rready
    );

    modport master (
        output s_axi_araddr, s_axi_arprot, s_axi_arvalid, s_axi_rready,
        output m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid,
        input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
        input  m_axi_araddr, m_axi_arprot, m_axi_arvalid, m_axi_rready
    );

endinterface

// File: rtl/axi_lite_read_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request searching from ptr upward, wrapping.
// Channel-agnostic so the same block can front a write-channel arbiter.
import axi_arb_pkg::*;

module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   grant,
    output logic               any_req
);

    int idx;

    always_comb begin
        grant   = '0;
        any_req = 1'b0;
        idx     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                grant   = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/axi_lite_read_arbiter.sv
// Shares one AXI4-Lite read channel among NUM_REQ masters, one outstanding transaction at a time.
// The grant is held from arbitration until the R handshake, then the pointer moves past it.
//
// state | meaning
// IDLE  | no transaction; pick a requester if any arvalid is set
// ADDR  | granted address presented downstream, waiting for m_axi_arready
// DATA  | waiting for the R handshake between slave and granted requester
import axi_arb_pkg::*;

module axi_lite_read_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    axi_lite_read_arbiter_if.slave  bus
);

    localparam int IDX_W = idx_width(NUM_REQ);

    arb_state_t       state, state_nxt;
    logic [IDX_W-1:0] g, g_nxt;
    logic [IDX_W-1:0] ptr, ptr_nxt;
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] g_inc;
    logic             any_req;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req     (bus.s_axi_arvalid),
        .ptr     (ptr),
        .grant   (pick),
        .any_req (any_req)
    );

    assign g_inc = (int'(g) == NUM_REQ - 1) ? '0 : g + IDX_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            g     <= '0;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            g     <= g_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        g_nxt     = g;
        ptr_nxt   = ptr;
        case (state)
            IDLE: begin
                if (any_req) begin
                    g_nxt     = pick;
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                if (bus.m_axi_arready) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (bus.m_axi_rvalid && bus.s_axi_rready[g]) begin
                    ptr_nxt   = g_inc;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Address is routed combinationally; the requester holds it stable until arready.
    always_comb begin
        bus.m_axi_arvalid = 1'b0;
        bus.m_axi_araddr  = '0;
        bus.m_axi_arprot  = '0;
        bus.s_axi_arready = '0;
        bus.m_axi_rready  = 1'b0;
        bus.s_axi_rvalid  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.s_axi_rdata[i] = bus.m_axi_rdata;
            bus.s_axi_rresp[i] = bus.m_axi_rresp;
        end
        case (state)
            ADDR: begin
                bus.m_axi_arvalid    = 1'b1;
                bus.m_axi_araddr     = bus.s_axi_araddr[g];
                bus.m_axi_arprot     = bus.s_axi_arprot[g];
                bus.s_axi_arready[g] = bus.m_axi_arready;
            end
            DATA: begin
                bus.s_axi_rvalid[g] = bus.m_axi_rvalid;
                bus.m_axi_rready    = bus.s_axi_rready[g];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi_lite_read_arbiter.sv
// Directed bench for axi_lite_read_arbiter with AR/R scoreboards filled at stimulus time.
import axi_arb_pkg::*;

module tb_axi_lite_read_arbiter;

    localparam int N = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    axi_lite_read_arbiter_if #(.NUM_REQ(N)) bus ();

    axi_lite_read_arbiter #(.NUM_REQ(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int          idx;
        logic [31:0] addr;
        logic [2:0]  prot;
    } ar_exp_t;

    typedef struct {
        int          idx;
        logic [31:0] data;
        logic [1:0]  resp;
    } r_exp_t;

    ar_exp_t     ar_q[$];
    r_exp_t      r_q[$];
    logic [31:0] req_addr [N];
    logic [2:0]  req_prot [N];
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int i);
        return N'(1) << i;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] addr, input logic [2:0] prot);
        req_addr[i]          = addr;
        req_prot[i]          = prot;
        bus.s_axi_araddr[i]  = addr;
        bus.s_axi_arprot[i]  = prot;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_m_arvalid"}, 32'(bus.m_axi_arvalid), 32'd0);
        chk({tag, "_m_araddr"},  bus.m_axi_araddr, 32'd0);
        chk({tag, "_m_arprot"},  32'(bus.m_axi_arprot), 32'd0);
        chk({tag, "_s_arready"}, 32'(bus.s_axi_arready), 32'd0);
        chk({tag, "_m_rready"},  32'(bus.m_axi_rready), 32'd0);
        chk({tag, "_s_rvalid"},  32'(bus.s_axi_rvalid), 32'd0);
    endtask

    // Called at posedge+1 with the arbiter in IDLE and requester arvalids already driven.
    task automatic txn(input int idx, input logic [31:0] data, input logic [1:0] resp,
                       input int ar_stall, input int r_stall, input bit stop_in_data);
        ar_exp_t a;
        r_exp_t  r;
        a.idx = idx; a.addr = req_addr[idx]; a.prot = req_prot[idx];
        ar_q.push_back(a);
        if (!stop_in_data) begin
            r.idx = idx; r.data = data; r.resp = resp;
            r_q.push_back(r);
        end
        #1;
        chk_quiet("idle");
        step();
        for (int i = 0; i < ar_stall; i++) begin
            bus.m_axi_arready = 1'b0;
            #1;
            chk("ar_stall_valid", 32'(bus.m_axi_arvalid), 32'd1);
            chk("ar_stall_addr",  bus.m_axi_araddr, req_addr[idx]);
            chk("ar_stall_ready", 32'(bus.s_axi_arready), 32'd0);
            step();
        end
        bus.m_axi_arready = 1'b1;
        #1;
        chk("ar_hs_valid", 32'(bus.m_axi_arvalid), 32'd1);
        a = ar_q.pop_front();
        chk("ar_hs_addr",  bus.m_axi_araddr, a.addr);
        chk("ar_hs_prot",  32'(bus.m_axi_arprot), 32'(a.prot));
        chk("ar_hs_grant", 32'(bus.s_axi_arready), 32'(onehot(a.idx)));
        step();
        bus.m_axi_arready = 1'b0;
        bus.m_axi_rvalid  = 1'b1;
        bus.m_axi_rdata   = data;
        bus.m_axi_rresp   = resp;
        bus.s_axi_rready  = '0;
        for (int i = 0; i < r_stall; i++) begin
            #1;
            chk("r_stall_mready", 32'(bus.m_axi_rready), 32'd0);
            chk("r_stall_rvalid", 32'(bus.s_axi_rvalid), 32'(onehot(idx)));
            chk("r_stall_arready", 32'(bus.s_axi_arready), 32'd0);
            chk("r_stall_arvalid", 32'(bus.m_axi_arvalid), 32'd0);
            step();
        end
        if (stop_in_data) begin
            #1;
            chk("data_rvalid", 32'(bus.s_axi_rvalid), 32'(onehot(idx)));
        end else begin
            bus.s_axi_rready = onehot(idx);
            #1;
            chk("r_hs_mready", 32'(bus.m_axi_rready), 32'd1);
            r = r_q.pop_front();
            chk("r_hs_rvalid", 32'(bus.s_axi_rvalid), 32'(onehot(r.idx)));
            chk("r_hs_rdata",  bus.s_axi_rdata[r.idx], r.data);
            chk("r_hs_rresp",  32'(bus.s_axi_rresp[r.idx]), 32'(r.resp));
            step();
            bus.m_axi_rvalid = 1'b0;
            bus.m_axi_rdata  = '0;
            bus.m_axi_rresp  = '0;
            bus.s_axi_rready = '0;
        end
    endtask

    initial begin
        reset             = 1'b1;
        bus.s_axi_araddr  = '0;
        bus.s_axi_arprot  = '0;
        bus.s_axi_arvalid = '0;
        bus.s_axi_rready  = '0;
        bus.m_axi_arready = 1'b0;
        bus.m_axi_rdata   = '0;
        bus.m_axi_rresp   = '0;
        bus.m_axi_rvalid  = 1'b0;
        for (int i = 0; i < N; i++) begin
            req_addr[i] = '0;
            req_prot[i] = '0;
        end
        #2;
        chk_quiet("in_reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk_quiet("after_reset");

        // Spurious slave rvalid while idle must not be acknowledged.
        bus.m_axi_rvalid = 1'b1;
        #1;
        chk("spurious_mready", 32'(bus.m_axi_rready), 32'd0);
        chk("spurious_rvalid", 32'(bus.s_axi_rvalid), 32'd0);
        step();
        bus.m_axi_rvalid = 1'b0;

        // Lone requester 1.
        set_req(1, 32'h0000_0100, 3'b010);
        bus.s_axi_arvalid = 2'b10;
        txn(1, 32'hDEAD_BEEF, OKAY, 0, 0, 1'b0);

        // Both requesting continuously: 0,1,0,1 with stalls and an error response mixed in.
        set_req(0, 32'h0000_0010, 3'b001);
        set_req(1, 32'h0000_0020, 3'b010);
        bus.s_axi_arvalid = 2'b11;
        txn(0, 32'h1111_0000, OKAY,   4, 0, 1'b0);
        txn(1, 32'h2222_0001, SLVERR, 0, 0, 1'b0);
        txn(0, 32'h3333_0002, OKAY,   0, 3, 1'b0);
        txn(1, 32'h4444_0003, OKAY,   0, 0, 1'b0);

        // Advance ptr to 1, then reset mid-DATA and confirm ptr returns to 0.
        bus.s_axi_arvalid = 2'b01;
        txn(0, 32'h5555_0004, OKAY, 0, 0, 1'b0);
        bus.s_axi_arvalid = 2'b11;
        txn(1, 32'h6666_0005, OKAY, 0, 0, 1'b1);
        reset = 1'b1;
        #1;
        chk_quiet("reset_in_data");
        bus.m_axi_rvalid = 1'b0;
        bus.m_axi_rdata  = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        txn(0, 32'h7777_0006, OKAY,   0, 0, 1'b0);
        txn(1, 32'h8888_0007, SLVERR, 0, 0, 1'b0);
        bus.s_axi_arvalid = '0;

        chk("ar_q_empty", 32'(ar_q.size()), 32'd0);
        chk("r_q_empty",  32'(r_q.size()),  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
